// File: rtl/timer_pkg.sv
// Shared definitions for the BCD mm:ss countdown timer.
//   timer_state_e : controller state encoding
//   c_BCD_WIDTH   : width of one BCD digit
//   c_MAX_NINE / c_MAX_FIVE : digit limits used on load clamp and borrow wrap
package timer_pkg;

  localparam int c_BCD_WIDTH = 4;
  localparam int c_MAX_NINE  = 9;
  localparam int c_MAX_FIVE  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bundle of the countdown timer.
//   master : drives tick/load/start/stop, observes the digits and status
//   slave  : the timer itself
interface countdown_timer_if;
  import timer_pkg::*;

  logic                   i_Tick;
  logic                   i_Load;
  logic [15:0]            i_Load_Data;
  logic                   i_Start;
  logic                   i_Stop;
  logic [c_BCD_WIDTH-1:0] o_Min_Tens;
  logic [c_BCD_WIDTH-1:0] o_Min_Ones;
  logic [c_BCD_WIDTH-1:0] o_Sec_Tens;
  logic [c_BCD_WIDTH-1:0] o_Sec_Ones;
  logic                   o_Running;
  logic                   o_Done;
  logic                   o_Zero;

  modport master (
    output i_Tick, i_Load, i_Load_Data, i_Start, i_Stop,
    input  o_Min_Tens, o_Min_Ones, o_Sec_Tens, o_Sec_Ones,
    input  o_Running, o_Done, o_Zero
  );

  modport slave (
    input  i_Tick, i_Load, i_Load_Data, i_Start, i_Stop,
    output o_Min_Tens, o_Min_Ones, o_Sec_Tens, o_Sec_Ones,
    output o_Running, o_Done, o_Zero
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit.
//   i_Clock, i_Reset_n : clock, async active-low reset (to c_RESET_VAL)
//   i_Load / i_Load_Value : load, clamped to c_MAX
//   i_Borrow_In : decrement this cycle; 0 wraps to c_MAX
//   o_Data : current digit; o_Borrow : borrow to the next digit (combinational)
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter int                     c_MAX       = 9,
  parameter logic [c_BCD_WIDTH-1:0] c_RESET_VAL = '0
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Load,
  input  logic [c_BCD_WIDTH-1:0] i_Load_Value,
  input  logic                   i_Borrow_In,
  output logic [c_BCD_WIDTH-1:0] o_Data,
  output logic                   o_Borrow
);

  localparam logic [c_BCD_WIDTH-1:0] c_MAX_V = c_BCD_WIDTH'(c_MAX);

  logic [c_BCD_WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (i_Load) begin
      data_d = (i_Load_Value > c_MAX_V) ? c_MAX_V : i_Load_Value;
    end else if (i_Borrow_In) begin
      data_d = (data_q == '0) ? c_MAX_V : data_q - c_BCD_WIDTH'(1);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) data_q <= c_RESET_VAL;
    else            data_q <= data_d;
  end

  assign o_Data   = data_q;
  assign o_Borrow = i_Borrow_In && (data_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with load/start/stop control and expiry pulse.
//   i_Clock, i_Reset_n : clock, async active-low reset
//   tmr (slave)        : tick/load/start/stop in; digits, running, done, zero out
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | preset loaded or reset, waiting for start
// ST_RUNNING | decrementing once per tick
// ST_PAUSED  | value frozen, start resumes
// ST_EXPIRED | reached 00:00 while running, held until a load
module countdown_timer
  import timer_pkg::*;
#(
  parameter logic [15:0] c_RESET_VALUE = 16'h0000,
  parameter int          c_DIGIT_WIDTH = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  countdown_timer_if.slave  tmr
);

  logic [c_DIGIT_WIDTH-1:0] mt, mo, st, so;
  logic so_borrow, st_borrow, mo_borrow, mt_borrow_unused;
  logic zero, at_one, dec_en;

  timer_state_e state_q, state_d;
  logic         running_q, running_d;
  logic         done_q, done_d;

  assign zero   = ({mt, mo, st, so} == 16'h0000);
  assign at_one = ({mt, mo, st, so} == 16'h0001);

  // Priority: load > stop > start > tick. A load always returns to IDLE.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    dec_en  = 1'b0;
    if (tmr.i_Load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!tmr.i_Stop && tmr.i_Start && !zero) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (tmr.i_Stop) begin
            state_d = ST_PAUSED;
          end else if (tmr.i_Tick) begin
            dec_en = 1'b1;
            if (at_one) begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (!tmr.i_Stop && tmr.i_Start) state_d = ST_RUNNING;
        end
        default: state_d = ST_EXPIRED;
      endcase
    end
    running_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  bcd_down_digit #(.c_MAX(c_MAX_NINE), .c_RESET_VAL(c_RESET_VALUE[3:0])) u_sec_ones (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Load(tmr.i_Load),
    .i_Load_Value(tmr.i_Load_Data[3:0]), .i_Borrow_In(dec_en),
    .o_Data(so), .o_Borrow(so_borrow)
  );

  bcd_down_digit #(.c_MAX(c_MAX_FIVE), .c_RESET_VAL(c_RESET_VALUE[7:4])) u_sec_tens (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Load(tmr.i_Load),
    .i_Load_Value(tmr.i_Load_Data[7:4]), .i_Borrow_In(so_borrow),
    .o_Data(st), .o_Borrow(st_borrow)
  );

  bcd_down_digit #(.c_MAX(c_MAX_NINE), .c_RESET_VAL(c_RESET_VALUE[11:8])) u_min_ones (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Load(tmr.i_Load),
    .i_Load_Value(tmr.i_Load_Data[11:8]), .i_Borrow_In(st_borrow),
    .o_Data(mo), .o_Borrow(mo_borrow)
  );

  // Never borrows in practice: decrement is only enabled above 00:00.
  bcd_down_digit #(.c_MAX(c_MAX_NINE), .c_RESET_VAL(c_RESET_VALUE[15:12])) u_min_tens (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Load(tmr.i_Load),
    .i_Load_Value(tmr.i_Load_Data[15:12]), .i_Borrow_In(mo_borrow),
    .o_Data(mt), .o_Borrow(mt_borrow_unused)
  );

  assign tmr.o_Min_Tens = mt;
  assign tmr.o_Min_Ones = mo;
  assign tmr.o_Sec_Tens = st;
  assign tmr.o_Sec_Ones = so;
  assign tmr.o_Running  = running_q;
  assign tmr.o_Done     = done_q;
  assign tmr.o_Zero     = zero;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
  import timer_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  countdown_timer_if tif ();

  countdown_timer #(.c_RESET_VALUE(16'h0130), .c_DIGIT_WIDTH(4)) dut (
    .i_Clock  (clk),
    .i_Reset_n(rst_n),
    .tmr      (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] value();
    return {tif.o_Min_Tens, tif.o_Min_Ones, tif.o_Sec_Tens, tif.o_Sec_Ones};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    tif.i_Tick  = 1'b0;
    tif.i_Load  = 1'b0;
    tif.i_Start = 1'b0;
    tif.i_Stop  = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] d);
    tif.i_Load      = 1'b1;
    tif.i_Load_Data = d;
    step();
    tif.i_Load      = 1'b0;
  endtask

  task automatic do_start();
    tif.i_Start = 1'b1;
    step();
    tif.i_Start = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    tif.i_Tick = 1'b1;
    for (int i = 0; i < n; i++) step();
    tif.i_Tick = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    tif.i_Load_Data = 16'h0000;
    rst_n = 1'b1;

    // Asynchronous reset, observed before the first clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_value", value(), 16'h0130);
    check("rst_running", 16'(tif.o_Running), 16'h0);
    check("rst_done", 16'(tif.o_Done), 16'h0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_hold", value(), 16'h0130);

    // 01:00 countdown to expiry.
    do_load(16'h0100);
    check("load_0100", value(), 16'h0100);
    check("load_idle", 16'(tif.o_Running), 16'h0);
    do_start();
    check("start_running", 16'(tif.o_Running), 16'h1);
    check("start_no_dec", value(), 16'h0100);
    do_ticks(1);
    check("borrow_0059", value(), 16'h0059);
    do_ticks(58);
    check("at_0001", value(), 16'h0001);
    check("at_0001_done", 16'(tif.o_Done), 16'h0);
    do_ticks(1);
    check("expire_value", value(), 16'h0000);
    check("expire_done", 16'(tif.o_Done), 16'h1);
    check("expire_zero", 16'(tif.o_Zero), 16'h1);
    check("expire_running", 16'(tif.o_Running), 16'h0);
    step();
    check("done_one_cycle", 16'(tif.o_Done), 16'h0);
    do_ticks(3);
    check("expired_hold", value(), 16'h0000);
    check("expired_hold_done", 16'(tif.o_Done), 16'h0);
    do_start();
    check("expired_start_ign", 16'(tif.o_Running), 16'h0);

    // Borrow through all four digits.
    do_load(16'h1000);
    check("zero_low_1000", 16'(tif.o_Zero), 16'h0);
    do_start();
    do_ticks(1);
    check("borrow_0959", value(), 16'h0959);

    // Stop beats a coincident tick; paused ignores ticks.
    do_load(16'h0005);
    do_start();
    tif.i_Stop = 1'b1;
    tif.i_Tick = 1'b1;
    step();
    clear_inputs();
    check("stop_tick_value", value(), 16'h0005);
    check("stop_paused", 16'(tif.o_Running), 16'h0);
    do_ticks(3);
    check("paused_ticks", value(), 16'h0005);
    do_start();
    check("resume_running", 16'(tif.o_Running), 16'h1);
    do_ticks(2);
    check("resume_0003", value(), 16'h0003);

    // Load sanitising and zero-start rejection.
    do_load(16'h9F7C);
    check("sanitise_9959", value(), 16'h9959);
    check("sanitise_idle", 16'(tif.o_Running), 16'h0);
    do_load(16'h0000);
    do_start();
    check("zero_start_ign", 16'(tif.o_Running), 16'h0);
    check("zero_start_val", value(), 16'h0000);

    // Load wins over a coincident tick at 00:01; no expiry.
    do_load(16'h0001);
    do_start();
    tif.i_Load      = 1'b1;
    tif.i_Load_Data = 16'h0002;
    tif.i_Tick      = 1'b1;
    step();
    clear_inputs();
    check("load_tick_value", value(), 16'h0002);
    check("load_tick_idle", 16'(tif.o_Running), 16'h0);
    check("load_tick_done", 16'(tif.o_Done), 16'h0);
    step();
    check("load_tick_done2", 16'(tif.o_Done), 16'h0);

    // Expire, then reset while o_Done is high.
    do_start();
    do_ticks(2);
    check("pre_rst_done", 16'(tif.o_Done), 16'h1);
    rst_n = 1'b0;
    #2;
    check("midrst_value", value(), 16'h0130);
    check("midrst_done", 16'(tif.o_Done), 16'h0);
    check("midrst_running", 16'(tif.o_Running), 16'h0);

    // Reset in the middle of a count.
    step();
    rst_n = 1'b1;
    do_load(16'h0010);
    do_start();
    do_ticks(1);
    check("count_0009", value(), 16'h0009);
    rst_n = 1'b0;
    #2;
    check("midcount_rst_val", value(), 16'h0130);
    check("midcount_rst_run", 16'(tif.o_Running), 16'h0);
    step();
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- BCD mm:ss countdown timer, the down-counting counterpart of the clock's up-counting digit chain.
- Loads a preset, then decrements once per i_Tick while running, propagating borrow across the four digits.
- Signals expiry with a one-cycle pulse and holds at 00:00.
- Sits beside the timekeeping chain and shares the 1 Hz tick and the display mux.

Parameters:
- c_RESET_VALUE, 16'h0000, BCD preset {min_tens, min_ones, sec_tens, sec_ones} loaded at reset; must be valid BCD with sec_tens ≤ 5.
- c_DIGIT_WIDTH, 4, width of one BCD digit.

Ports:
- i_Clock  in  1  system clock
- i_Reset_n  in  1  reset; asynchronous, active-low
- i_Tick  in  1  one-cycle 1 Hz enable pulse
- i_Load  in  1  load i_Load_Data (one-cycle pulse)
- i_Load_Data  in  16  BCD preset {MT, MO, ST, SO}
- i_Start  in  1  start/resume pulse
- i_Stop  in  1  pause pulse
- o_Min_Tens, o_Min_Ones, o_Sec_Tens, o_Sec_Ones  out  4 each  current BCD value
- o_Running  out  1  high in RUNNING
- o_Done  out  1  one-cycle expiry pulse
- o_Zero  out  1  combinational: value == 00:00

Behaviour:
- Reset (async, i_Reset_n=0): digits = c_RESET_VALUE, state IDLE, o_Running=0, o_Done=0.
- States: IDLE, RUNNING, PAUSED, EXPIRED. All registers update on posedge i_Clock.
- Priority each cycle: i_Load > i_Stop > i_Start > i_Tick.
- IDLE:
  - i_Load: latch data, stay IDLE.
  - i_Start with value ≠ 0: go to RUNNING.
  - i_Start with value = 0: ignored.
- RUNNING:
  - i_Tick: decrement once.
  - i_Stop: go to PAUSED, no decrement that cycle even if i_Tick is high.
  - i_Load: latch data, go to IDLE.
- PAUSED:
  - i_Tick: ignored.
  - i_Start: back to RUNNING.
  - i_Load: latch data, go to IDLE.
- EXPIRED:
  - Value held at 00:00; i_Tick and i_Start ignored.
  - i_Load: latch data, go to IDLE.
- Decrement: borrow chain SO→ST→MO→MT.
  - SO 0→9 with borrow out; ST 0→5 with borrow out; MO 0→9 with borrow out; MT 0→9.
  - A digit decrements only when its borrow-in is high.
- Expiry: the RUNNING tick that takes the value from 00:01 to 00:00 moves state to EXPIRED on the same edge. o_Done is high exactly the following cycle, then 0.
- Load sanitising, per digit:
  - SO/MO/MT > 9 clamps to 9; ST > 5 clamps to 5.
  - Loaded 00:00 remains IDLE.
- Latency: i_Tick → new digit values visible 1 cycle later (registered outputs).
- Max value 99:59; no wrap below 00:00.
- Reset mid-operation: immediate return to c_RESET_VALUE/IDLE; a pending o_Done is cleared.

Decomposition:
- Shared package (timer_pkg): state encoding constants (IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, EXPIRED=2'd3), digit limits (9, 5), BCD width.
- Sub-module bcd_down_digit, one per digit:
  - Parameter c_MAX (9 or 5).
  - Ports: i_Clock, i_Reset_n, i_Load, i_Load_Value, i_Borrow_In, o_Data, o_Borrow (combinational: i_Borrow_In && o_Data==0).
  - Instantiated four times.

Test Plan:
- Reset with c_RESET_VALUE=16'h0130 → digits 0,1,3,0, o_Running=0, o_Done=0, asynchronously before the next clock edge.
- Load 16'h0100, i_Start, 1 tick → 00:59 with ST/SO borrow; 59 more ticks → 00:00, state EXPIRED, o_Done=1 for exactly one cycle, o_Zero=1; further ticks leave 00:00.
- Load 16'h1000, start, 1 tick → 09:59 (borrow across all four digits).
- Running at 00:05: i_Stop and i_Tick in the same cycle → stays 00:05, PAUSED; 3 ticks → still 00:05; i_Start + 2 ticks → 00:03.
- Load 16'h9F7C → sanitised 99:59; i_Start with loaded 00:00 → remains IDLE, o_Running=0.
- Running at 00:01: i_Load 16'h0002 coincident with i_Tick → value 00:02, IDLE, no o_Done. Then drop i_Reset_n mid-count → immediate c_RESET_VALUE.
